// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings
// and the default timing constants used by the top level.
package btn_pkg;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_HELD         = 3'd2;
  localparam logic [2:0] S_REPEAT       = 3'd3;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE         = S_IDLE,
    PRESS_WAIT   = S_PRESS_WAIT,
    HELD         = S_HELD,
    REPEAT       = S_REPEAT,
    RELEASE_WAIT = S_RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_STABLE_CYC  = 500000;
  localparam int unsigned DEF_HOLD_CYC    = 50000000;
  localparam int unsigned DEF_REPEAT_CYC  = 10000000;
  localparam bit          DEF_REPEAT_EN   = 1'b1;
  localparam int unsigned DEF_CW          = 26;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; q_o is d_i delayed
// by STAGES clock edges. Synchronous active-high reset clears the chain.
module sync_ff
  import btn_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // NOTE: clocked state uses <= so every flop samples its input before any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce by cycle-count qualification,
// and emit single-cycle press / auto-repeat / release pulses plus a clean level.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYC  = DEF_STABLE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC  = DEF_REPEAT_CYC,
  parameter bit          REPEAT_EN   = DEF_REPEAT_EN,
  parameter int unsigned CW          = DEF_CW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);
  localparam bit            NO_QUAL     = (STABLE_CYC == 1);

  logic sync_q;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (sync_q)
  );

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          release_q, release_d;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    level_d   = level_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        cnt_d   = '0;
        if (sync_q) begin
          if (NO_QUAL) begin
            state_d = HELD;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end

      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end
      end

      HELD, REPEAT: begin
        if (!sync_q) begin
          // With single-sample qualification the release is accepted at once.
          if (NO_QUAL) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end else if (state_q == HELD && REPEAT_EN && cnt_q == HOLD_LAST) begin
          state_d = REPEAT;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else if (state_q == REPEAT && cnt_q == REPEAT_LAST) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (sync_q) begin
          // A release bounce restarts the hold timer without emitting a pulse.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
        level_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse: a per-cycle vector table for press
// and bounce rejection, then directed sequences for repeat, release and reset.
module tb_btn_debounce_pulse;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  logic lv0, pu0, re0;  // main config: STABLE 4, HOLD 20, REPEAT 8, repeat on
  logic lv1, pu1, re1;  // same timing, repeat off
  logic lv2, pu2, re2;  // single-sample qualification

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .SYNC_STAGES(2), .STABLE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(8), .REPEAT_EN(1'b1), .CW(8)
  ) u0 (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lv0), .btn_pulse(pu0), .btn_release(re0)
  );

  btn_debounce_pulse #(
    .SYNC_STAGES(2), .STABLE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(8), .REPEAT_EN(1'b0), .CW(8)
  ) u1 (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lv1), .btn_pulse(pu1), .btn_release(re1)
  );

  btn_debounce_pulse #(
    .SYNC_STAGES(2), .STABLE_CYC(1), .HOLD_CYC(20), .REPEAT_CYC(8), .REPEAT_EN(1'b1), .CW(8)
  ) u2 (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lv2), .btn_pulse(pu2), .btn_release(re2)
  );

  typedef struct packed {
    logic rst;
    logic btn;
    logic level;
    logic pulse;
    logic rel;
  } vec_t;

  vec_t tbl [0:22];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Raise the button and wait for u0's press pulse; returns that edge.
  task automatic press(input string tag, output int a);
    int n;
    int a1;
    int a2;
    a  = -1;
    a1 = -1;
    a2 = -1;
    btn = 1'b1;
    n = cyc + 1;
    for (int k = 0; k < 12 && a < 0; k++) begin
      tick();
      if (pu0 && a < 0)  a  = cyc;
      if (pu1 && a1 < 0) a1 = cyc;
      if (pu2 && a2 < 0) a2 = cyc;
    end
    check({tag, " u0 press latency"}, a - n, 5);
    check({tag, " u1 press latency"}, a1 - n, 5);
    check({tag, " u2 press latency"}, a2 - n, 2);
  endtask

  initial begin
    int a;
    int r;
    int first;
    int npu;
    int nre;
    int nlow;
    int both;
    int rel1;
    int rel2;
    int pq[$];
    int rq[$];
    int exp_p[4];

    // Clean press: btn first sampled high at vector 2 (edge N), accepted at N+5.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    // Bounce: high 3, low 1, high 2, low -> never qualified.
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i <= 22; i++) begin
      rst = tbl[i].rst;
      btn = tbl[i].btn;
      tick();
      check($sformatf("vec%0d level", i),   int'(lv0), int'(tbl[i].level));
      check($sformatf("vec%0d pulse", i),   int'(pu0), int'(tbl[i].pulse));
      check($sformatf("vec%0d release", i), int'(re0), int'(tbl[i].rel));
    end

    // Auto-repeat: pulses at A+20/28/36/44, button low from A+49, release at A+54.
    do_reset();
    press("repeat", a);
    pq.delete();
    rq.delete();
    both = 0;
    for (int i = 1; i <= 60; i++) begin
      btn = (i < 49);
      tick();
      if (pu0) pq.push_back(i);
      if (re0) rq.push_back(i);
      if (pu0 && re0) both++;
      if (i == 53) check("repeat level before release", int'(lv0), 1);
    end
    exp_p = '{20, 28, 36, 44};
    check("repeat pulse count", pq.size(), 4);
    for (int j = 0; j < 4; j++)
      check($sformatf("repeat pulse%0d offset", j), (pq.size() > j) ? pq[j] : -1, exp_p[j]);
    check("repeat release count", rq.size(), 1);
    check("repeat release offset", (rq.size() > 0) ? rq[0] : -1, 54);
    check("repeat level after release", int'(lv0), 0);
    check("repeat pulse with release", both, 0);

    // Release bounce while HELD: hold timer restarts, next repeat at A+30.
    do_reset();
    press("bounce", a);
    pq.delete();
    nre  = 0;
    nlow = 0;
    for (int i = 1; i <= 35; i++) begin
      btn = !(i == 6 || i == 7);
      tick();
      if (pu0) pq.push_back(i);
      if (re0) nre++;
      if (!lv0) nlow++;
    end
    check("bounce pulse count", pq.size(), 1);
    check("bounce repeat offset", (pq.size() > 0) ? pq[0] : -1, 30);
    check("bounce release count", nre, 0);
    check("bounce level low cycles", nlow, 0);

    // Repeat disabled: one pulse per press; release latencies for u1 and u2.
    do_reset();
    press("norepeat", a);
    npu = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pu1) npu++;
    end
    check("norepeat extra pulses", npu, 0);
    check("norepeat level held", int'(lv1), 1);
    npu  = 0;
    nre  = 0;
    rel1 = -1;
    rel2 = -1;
    btn  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pu1) npu++;
      if (re1) begin
        nre++;
        if (rel1 < 0) rel1 = i;
      end
      if (re2 && rel2 < 0) rel2 = i;
    end
    check("norepeat release count", nre, 1);
    check("norepeat pulses on release", npu, 0);
    check("norepeat release latency", rel1, 6);
    check("single-sample release latency", rel2, 3);
    check("norepeat level released", int'(lv1), 0);

    // Reset mid-hold with the button still down: one fresh press afterwards.
    do_reset();
    press("midreset", a);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    check("midreset level", int'(lv0), 0);
    check("midreset pulse", int'(pu0), 0);
    check("midreset release", int'(re0), 0);
    check("midreset u1 level", int'(lv1), 0);
    rst   = 1'b0;
    r     = cyc;
    first = -1;
    npu   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pu0) begin
        npu++;
        if (first < 0) first = cyc;
      end
    end
    check("midreset pulse latency", first - r, 6);
    check("midreset pulse count", npu, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
Conditions a raw, asynchronous push-button into clean single-cycle enable pulses for the mod-n counter stage. It sits directly upstream of that counter: btn_pulse drives the counter's en input.
The block has three functions:
- a synchroniser;
- a debounce FSM with cycle-count qualification;
- optional hold-to-auto-repeat.
It also provides a debounced level output and a release pulse for other consumers.

Parameters:
SYNC_STAGES, 2, synchroniser flop count (>=2)
STABLE_CYC, 500000, consecutive synchronised samples needed to accept a press or a release (>=1)
HOLD_CYC, 50000000, cycles from the accepted press to the first auto-repeat pulse
REPEAT_CYC, 10000000, cycles between subsequent auto-repeat pulses
REPEAT_EN, 1, 1 enables auto-repeat; 0 gives one pulse per press
CW, 26, internal counter width; must satisfy 2^CW > max(STABLE_CYC, HOLD_CYC, REPEAT_CYC)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
btn_in  in  1  raw button, asynchronous to clk, may bounce
btn_level  out  1  debounced button level
btn_pulse  out  1  one-cycle pulse per accepted press and per auto-repeat
btn_release  out  1  one-cycle pulse per accepted release

Behaviour:
- Reset (rst=1 at posedge, dominates all other inputs):
  - synchroniser flops, counter and all outputs go to 0; FSM goes to IDLE.
  - A button still held after reset deasserts is detected as a fresh press after the full latency (exactly one pulse).
- Synchroniser: SYNC_STAGES-flop chain; sync_q is btn_in delayed by SYNC_STAGES edges. The FSM uses only sync_q.
- All outputs are registered. btn_pulse and btn_release are high for exactly one cycle per event and never in the same cycle.
- FSM states:
  - IDLE: btn_level=0. If sync_q=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - sync_q=0: return to IDLE with no output (glitch rejected).
    - sync_q=1 and cnt==STABLE_CYC-1: go to HELD, set btn_level=1, pulse btn_pulse, cnt=0.
    - otherwise: cnt++.
  - HELD:
    - sync_q=0: go to RELEASE_WAIT, cnt=1.
    - REPEAT_EN=1 and cnt==HOLD_CYC-1: pulse btn_pulse, go to REPEAT, cnt=0.
    - otherwise: cnt++ (saturating).
  - REPEAT:
    - sync_q=0: go to RELEASE_WAIT, cnt=1.
    - cnt==REPEAT_CYC-1: pulse btn_pulse, cnt=0.
    - otherwise: cnt++.
  - RELEASE_WAIT: btn_level stays 1.
    - sync_q=1: return to HELD with cnt=0. No pulse; the hold timer restarts, so a bounce never produces an extra pulse.
    - sync_q=0 and cnt==STABLE_CYC-1: go to IDLE, set btn_level=0, pulse btn_release.
    - otherwise: cnt++.
- Press latency: if edge N is the first edge that samples btn_in=1 and btn_in stays high, btn_level and btn_pulse rise on edge N+SYNC_STAGES+STABLE_CYC-1. Release latency is symmetric.
- Auto-repeat timing: the first repeat pulse comes HOLD_CYC cycles after the press pulse, then one every REPEAT_CYC cycles.
- STABLE_CYC=1: a press is accepted on the first sync_q=1 sample, bypassing the PRESS_WAIT count.
- The counter never wraps; it saturates at 2^CW-1.
- Unused state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package (btn_pkg): FSM state encodings (3-bit localparams IDLE..RELEASE_WAIT) and default timing constants.
- One sub-module, sync_ff: parameterised SYNC_STAGES flop chain with synchronous reset to 0.
- The FSM and counter live in btn_debounce_pulse.

Test Plan:
(All scenarios override SYNC_STAGES=2, STABLE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8, REPEAT_EN=1 unless stated.)
1. Clean press: btn_in rises before edge N, held -> btn_level and btn_pulse rise at edge N+5; btn_pulse=1 for exactly one cycle; btn_level stays 1.
2. Bounce rejection: btn_in high 3 cycles, low 1, high 2, low -> no btn_pulse, btn_level stays 0, FSM ends in IDLE.
3. Auto-repeat: press accepted at edge A, held 50 more cycles -> btn_pulse at A, A+20, A+28, A+36, A+44 (5 pulses); release then gives btn_release once, 4 cycles after sync_q falls.
4. Release bounce: while HELD, btn_in low 2 cycles then high -> btn_level stays 1, no btn_release, no extra btn_pulse, next repeat pulse 20 cycles later.
5. REPEAT_EN=0: hold btn_in 100 cycles -> exactly one btn_pulse; one btn_release after release.
6. Reset mid-hold: rst=1 for 1 cycle while HELD with btn_in held -> all outputs 0 at that edge; a new btn_pulse follows exactly SYNC_STAGES+STABLE_CYC-1 edges after the first post-reset edge.
